mm_iddmm_csub: RTL and testbench

Final conditional-subtract stage for the IDDMM Montgomery multiplier, parametrised successor of the fixed-length compare/subtract block. It takes the multiplier's accumulator a (words a(L-1..0) in RAM A, plus the overflow word an in a register) and modulus m (RAM M). It returns (a - m) if a >= m, else a, low word first, and clears the consumed RAM A words. New capabilities over the previous generation:
- Runtime operand length L
- Full K-bit an compare
- Synchronous (1-cycle) RAM reads
- res_last / res_sub status
- Synchronous reset

---
 rtl/mm_iddmm_csub.sv | 142 ++++++++++++++
 tb/tb_mm_iddmm_csub.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mm_iddmm_csub.sv
// Final conditional-subtract stage of the IDDMM Montgomery multiplier: streams
// (a - m) if a >= m else a, low word first, and clears the consumed RAM A words.
module mm_iddmm_csub #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              task_req,
  input  logic [ADDR_W:0]   task_len,
  output logic              task_busy,
  output logic [K-1:0]      res,
  output logic              res_val,
  output logic              res_last,
  output logic              res_sub,
  output logic              task_end,
  output logic              an_clr,
  output logic [ADDR_W-1:0] addr_a,
  input  logic [K-1:0]      aj,
  input  logic [K-1:0]      an,
  output logic [ADDR_W-1:0] addr_m,
  input  logic [K-1:0]      mj,
  output logic              clra_wren,
  output logic [ADDR_W-1:0] clra_addr
);

  typedef enum logic [2:0] {
    IDLE, CMP_MSW, CMP_RUN, DEC_SUB, DEC_NOP, OUT, OUT_END
  } state_t;

  localparam logic [ADDR_W:0] N_LEN = (ADDR_W+1)'(N);

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   len_m1;    // L-1 of the running task
  logic [ADDR_W-1:0]   len_sel;
  logic [ADDR_W-1:0]   idx;       // word whose compare data returns this cycle
  logic [ADDR_W:0]     out_cnt;   // next output address; one bit wider so L=N ends cleanly
  logic                sub_mode;
  logic                carry;
  logic                issue;
  logic                rd_v;      // read data on aj/mj belongs to the output stream
  logic [ADDR_W-1:0]   rd_addr;
  logic [K:0]          sum;

  // Out-of-range lengths fall back to the full operand size.
  always_comb begin
    if (task_len == '0 || task_len > N_LEN) len_sel = ADDR_W'(N - 1);
    else                                    len_sel = ADDR_W'(task_len - 1'b1);
  end

  // aj + ~mj + c is a - m word by word with the borrow carried as inverted carry.
  assign sum = {1'b0, aj} + {1'b0, ~mj} + {{K{1'b0}}, carry};

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_nx = state;
    addr_a   = '0;
    issue    = 1'b0;
    case (state)
      IDLE:    if (task_req) state_nx = CMP_MSW;
      CMP_MSW: begin
        addr_a   = idx;
        state_nx = (an != '0) ? DEC_SUB : CMP_RUN;
      end
      CMP_RUN: begin
        addr_a = (idx == '0) ? '0 : idx - 1'b1;
        if (aj > mj)          state_nx = DEC_SUB;
        else if (aj < mj)     state_nx = DEC_NOP;
        else if (idx == '0)   state_nx = DEC_SUB;
      end
      DEC_SUB, DEC_NOP: begin
        issue    = 1'b1;
        state_nx = OUT;
      end
      OUT: begin
        if (out_cnt <= {1'b0, len_m1}) begin
          addr_a = out_cnt[ADDR_W-1:0];
          issue  = 1'b1;
        end
        if (res_last) state_nx = OUT_END;
      end
      OUT_END: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign addr_m    = addr_a;
  assign task_busy = (state != IDLE);
  assign task_end  = (state == OUT_END);
  assign an_clr    = (state == OUT_END);
  assign res_sub   = (state == OUT_END) && sub_mode;

  // NOTE: all state updates are non-blocking so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_m1    <= '0;
      idx       <= '0;
      out_cnt   <= '0;
      sub_mode  <= 1'b0;
      carry     <= 1'b0;
      rd_v      <= 1'b0;
      rd_addr   <= '0;
      res       <= '0;
      res_val   <= 1'b0;
      res_last  <= 1'b0;
      clra_wren <= 1'b0;
      clra_addr <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (task_req) begin
          len_m1 <= len_sel;
          idx    <= len_sel;
        end
        CMP_RUN: if (idx != '0) idx <= idx - 1'b1;
        DEC_SUB, DEC_NOP: begin
          sub_mode <= (state == DEC_SUB);
          carry    <= 1'b1;
          out_cnt  <= (ADDR_W+1)'(1);
        end
        OUT: begin
          if (issue) out_cnt <= out_cnt + 1'b1;
          if (rd_v)  carry   <= sum[K];
        end
        default: ;
      endcase

      rd_v    <= issue;
      rd_addr <= addr_a;

      // The word is cleared in RAM A in the same cycle it is presented on res.
      res_val   <= rd_v;
      res_last  <= rd_v && (rd_addr == len_m1);
      res       <= rd_v ? (sub_mode ? sum[K-1:0] : aj) : '0;
      clra_wren <= rd_v;
      clra_addr <= rd_v ? rd_addr : '0;
    end
  end

endmodule

// File: tb/tb_mm_iddmm_csub.sv
// Directed bench for mm_iddmm_csub (K=8, N=4) against a big-integer model of
// the conditional subtract and its result schedule.
module tb_mm_iddmm_csub;
  localparam int K  = 8;
  localparam int N  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n, task_req, load_now;
  logic [AW:0]   task_len;
  logic          task_busy, res_val, res_last, res_sub, task_end, an_clr, clra_wren;
  logic [K-1:0]  res, aj, mj, an;
  logic [AW-1:0] addr_a, addr_m, clra_addr;

  logic [K-1:0]  ram_a[N], ram_m[N], init_a[N], init_m[N];
  int            clr_hits[N];

  int            cyc = 0, t0 = 0, t_stop = 0;
  bit            mon_on = 1'b0;
  int            n_checks = 0, n_err = 0;

  int            m_L, m_F;
  bit            m_sub;
  logic [K-1:0]  m_words[N];

  always #5 clk = ~clk;

  mm_iddmm_csub #(.K(K), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .task_req(task_req), .task_len(task_len),
    .task_busy(task_busy), .res(res), .res_val(res_val), .res_last(res_last),
    .res_sub(res_sub), .task_end(task_end), .an_clr(an_clr),
    .addr_a(addr_a), .aj(aj), .an(an), .addr_m(addr_m), .mj(mj),
    .clra_wren(clra_wren), .clra_addr(clra_addr)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAMs A and M; RAM A also takes the clear writes.
  always @(posedge clk) begin
    if (load_now) begin
      ram_a    <= init_a;
      ram_m    <= init_m;
      clr_hits <= '{default: 0};
    end else if (clra_wren) begin
      ram_a[clra_addr]    <= '0;
      clr_hits[clra_addr] <= clr_hits[clra_addr] + 1;
    end
    aj <= ram_a[addr_a];
    mj <= ram_m[addr_m];
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Whole-number model: A = an:a(L-1..0), M = m(L-1..0); the first result word
  // appears 4 cycles after the decision point given by the first differing word.
  task automatic predict(input logic [7:0] an_v, input logic [31:0] a_v,
                         input logic [31:0] m_v, input logic [2:0] len);
    logic [63:0] av, mv, rv;
    int j;
    m_L = (len == 0 || len > N) ? N : int'(len);
    av  = 64'(an_v) << (8 * m_L);
    mv  = '0;
    for (int i = 0; i < m_L; i++) begin
      av |= 64'(a_v[8*i +: 8]) << (8 * i);
      mv |= 64'(m_v[8*i +: 8]) << (8 * i);
    end
    m_sub = (av >= mv);
    rv    = m_sub ? av - mv : av;
    for (int i = 0; i < N; i++) m_words[i] = rv[8*i +: 8];
    j = -1;
    for (int i = m_L - 1; i >= 0; i--)
      if (j < 0 && a_v[8*i +: 8] != m_v[8*i +: 8]) j = i;
    m_F = (an_v != 0) ? 4 : ((j < 0) ? m_L + 4 : m_L - j + 4);
  endtask

  // Per-cycle compare of every streamed output against the model schedule.
  always @(negedge clk) begin
    if (mon_on) begin
      automatic int         t = cyc - t0;
      automatic bit         v = (t >= m_F && t < m_F + m_L);
      automatic bit         e = (t == m_F + m_L);
      automatic logic [7:0] w = 8'h00;
      if (v) w = m_words[t - m_F];
      if (t >= 1 && t <= t_stop)
        check($sformatf("outputs busy/val/last/end/anclr/sub/res at T%0d", t),
              {task_busy, res_val, res_last, task_end, an_clr, res_sub, res},
              {(t <= m_F + m_L), v, (t == m_F + m_L - 1), e, e, e && m_sub, w});
    end
  end

  task automatic run_task(input logic [7:0] an_v, input logic [31:0] a_v,
                          input logic [31:0] m_v, input logic [2:0] len,
                          input int pulse_mid, input int abort_at);
    predict(an_v, a_v, m_v, len);
    for (int i = 0; i < N; i++) begin
      init_a[i] = a_v[8*i +: 8];
      init_m[i] = m_v[8*i +: 8];
    end
    an = an_v;
    @(posedge clk); #1 load_now = 1'b1;
    @(posedge clk); #1 load_now = 1'b0;
    task_req = 1'b1;
    task_len = len;
    t0       = cyc;
    t_stop   = (abort_at > 0) ? abort_at : m_F + m_L + 1;
    mon_on   = 1'b1;
    for (int c = 1; c <= t_stop; c++) begin
      @(posedge clk); #1;
      task_req = (c == pulse_mid);
      if (c == abort_at) rst_n = 1'b0;
    end
    @(posedge clk); #1;
    mon_on   = 1'b0;
    task_req = 1'b0;
    if (abort_at > 0) begin
      check("outputs after mid-task reset",
            {task_busy, res_val, res_last, task_end, an_clr, res_sub, res,
             addr_a, addr_m, clra_wren, clra_addr}, '0);
      check("clears of word 2 after abort", clr_hits[2], 0);
      check("clears of word 3 after abort", clr_hits[3], 0);
      rst_n = 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("clears of word %0d", i), clr_hits[i], (i < m_L) ? 1 : 0);
        check($sformatf("ram_a word %0d after task", i), ram_a[i],
              (i < m_L) ? 8'h00 : init_a[i]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; task_req = 1'b0; task_len = '0; an = '0; load_now = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("outputs in reset",
          {task_busy, res_val, res_last, task_end, an_clr, res_sub, res,
           addr_a, addr_m, clra_wren, clra_addr}, '0);
    rst_n = 1'b1;

    // an != 0 forces subtraction without looking at the words.
    run_task(8'h01, 32'h00000005, 32'hFFFFFFFF, 3'd4, 0, 0);
    check("model s1 words", {m_words[3], m_words[2], m_words[1], m_words[0]}, 32'h00000006);
    check("model s1 first res_val cycle", m_F, 4);
    check("model s1 res_sub", m_sub, 1);

    // Mismatch only at word 0.
    run_task(8'h00, 32'h12345678, 32'h12345677, 3'd4, 0, 0);
    check("model s2 words", {m_words[3], m_words[2], m_words[1], m_words[0]}, 32'h00000001);
    check("model s2 first res_val cycle", m_F, 8);

    // a < m decided on the top word.
    run_task(8'h00, 32'h11FFFFFF, 32'h12000000, 3'd4, 0, 0);
    check("model s3 words", {m_words[3], m_words[2], m_words[1], m_words[0]}, 32'h11FFFFFF);
    check("model s3 first res_val cycle", m_F, 5);
    check("model s3 res_sub", m_sub, 0);

    // a == m gives zero and the longest schedule.
    run_task(8'h00, 32'hABCDEF01, 32'hABCDEF01, 3'd4, 0, 0);
    check("model s4 task_end cycle", m_F + m_L, 12);
    check("model s4 words", {m_words[3], m_words[2], m_words[1], m_words[0]}, 32'h00000000);

    // L=2 with junk in upper words and a stray task_req mid-task.
    run_task(8'h00, 32'h55AA8000, 32'h33CC7FFF, 3'd2, 3, 0);
    check("model s5 words", {m_words[1], m_words[0]}, 16'h0001);
    check("model s5 first res_val cycle", m_F, 5);

    // Reset in the cycle of the second result word, then a clean task.
    run_task(8'h01, 32'h00000005, 32'hFFFFFFFF, 3'd4, 0, 5);
    run_task(8'h00, 32'h12345678, 32'h12345677, 3'd4, 0, 0);

    // task_len 0 means N; L=1 boundary.
    run_task(8'h00, 32'h11FFFFFF, 32'h12000000, 3'd0, 0, 0);
    check("model len0 length", m_L, 4);
    run_task(8'h00, 32'hEEEEEE07, 32'h00000009, 3'd1, 0, 0);
    check("model L1 word", m_words[0], 8'h07);
    check("model L1 first res_val cycle", m_F, 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
